branch_predict_unit: RTL and testbench

Parametrised branch unit for the MIPS core: predicts branch direction and target at fetch from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. At resolve it evaluates six MIPS conditional-branch types internally and computes the target as PC+4 plus the shifted offset. It issues a redirect on misprediction and trains the table. It sits between the PC register (fetch side) and the register-file/ALU operand path (resolve side).

---
 rtl/branch_predict_unit_if.sv | 53 +++++
 rtl/branch_predict_unit.sv | 138 +++++++++++++
 tb/tb_branch_predict_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_unit_if.sv
// Bundles the fetch and resolve signals of the branch unit.
// master: core side (drives fetch PC and resolve operands, receives predictions/redirects)
// slave : branch_predict_unit
//   fetch_pc        PC being fetched
//   pred_taken      predicted direction for fetch_pc
//   pred_target     predicted next PC for fetch_pc
//   res_valid       a branch resolves this cycle
//   res_pc          PC of the resolving branch
//   res_type        condition select (BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ/never)
//   res_rs/res_rt   operand values
//   res_offset      sign-extended immediate, unshifted
//   res_pred_taken  direction predicted at fetch
//   res_pred_target target used at fetch
//   redirect        misprediction, fetch loads redirect_pc
//   redirect_pc     correct next PC
//   actual_taken    resolved direction
//   branch_cnt      resolved branch count (saturating)
//   mispred_cnt     misprediction count (saturating)
interface branch_predict_unit_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 16
);
    logic [WIDTH-1:0]     fetch_pc;
    logic                 pred_taken;
    logic [WIDTH-1:0]     pred_target;
    logic                 res_valid;
    logic [WIDTH-1:0]     res_pc;
    logic [2:0]           res_type;
    logic [WIDTH-1:0]     res_rs;
    logic [WIDTH-1:0]     res_rt;
    logic [WIDTH-1:0]     res_offset;
    logic                 res_pred_taken;
    logic [WIDTH-1:0]     res_pred_target;
    logic                 redirect;
    logic [WIDTH-1:0]     redirect_pc;
    logic                 actual_taken;
    logic [CNT_WIDTH-1:0] branch_cnt;
    logic [CNT_WIDTH-1:0] mispred_cnt;

    modport master (
        output fetch_pc, res_valid, res_pc, res_type, res_rs, res_rt,
               res_offset, res_pred_taken, res_pred_target,
        input  pred_taken, pred_target, redirect, redirect_pc,
               actual_taken, branch_cnt, mispred_cnt
    );

    modport slave (
        input  fetch_pc, res_valid, res_pc, res_type, res_rs, res_rt,
               res_offset, res_pred_taken, res_pred_target,
        output pred_taken, pred_target, redirect, redirect_pc,
               actual_taken, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB branch predictor with 2-bit saturating counters.
// Fetch lookup and resolve/redirect are combinational; training and
// statistics update on the rising edge of clk. ENTRIES must be a power of two >= 2.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  branch_predict_unit_if.slave (fetch, resolve, redirect, statistics)
module branch_predict_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_predict_unit_if.slave  bus
);
    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = WIDTH - IDX - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] target;
        logic [1:0]       ctr;
    } btb_entry_t;

    btb_entry_t           btb_q [ENTRIES];
    btb_entry_t           ent_d;
    logic                 ent_we;
    logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

    // Word-offset bits of the PCs carry no information for indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.fetch_pc[1:0], bus.res_pc[1:0]};

    // Fetch lookup
    logic [IDX-1:0]   f_idx;
    logic [TAG_W-1:0] f_tag;
    btb_entry_t       f_ent;
    logic             f_hit;

    assign f_idx           = bus.fetch_pc[IDX+1:2];
    assign f_tag           = bus.fetch_pc[WIDTH-1:IDX+2];
    assign f_ent           = btb_q[f_idx];
    assign f_hit           = f_ent.valid && (f_ent.tag == f_tag);
    assign bus.pred_taken  = f_hit & f_ent.ctr[1];
    assign bus.pred_target = bus.pred_taken ? f_ent.target : bus.fetch_pc + WIDTH'(4);

    // Branch condition; zero compares are signed on rs
    logic taken;
    logic rs_neg, rs_zero;
    assign rs_neg  = bus.res_rs[WIDTH-1];
    assign rs_zero = (bus.res_rs == '0);

    always_comb begin
        taken = 1'b0;
        case (bus.res_type)
            3'b000:  taken = (bus.res_rs == bus.res_rt);
            3'b001:  taken = (bus.res_rs != bus.res_rt);
            3'b010:  taken = rs_neg | rs_zero;
            3'b011:  taken = ~rs_neg & ~rs_zero;
            3'b100:  taken = rs_neg;
            3'b101:  taken = ~rs_neg;
            default: taken = 1'b0;
        endcase
    end

    // Resolve target and redirect
    logic [WIDTH-1:0] seq_pc, br_target;
    assign seq_pc    = bus.res_pc + WIDTH'(4);
    assign br_target = seq_pc + (bus.res_offset << 2);

    assign bus.actual_taken = taken;
    assign bus.redirect_pc  = taken ? br_target : seq_pc;
    assign bus.redirect     = bus.res_valid &
                              ((taken != bus.res_pred_taken) |
                               (taken & (bus.res_pred_target != br_target)));

    // Training: update the indexed entry on hit, allocate on taken miss
    logic [IDX-1:0]   r_idx;
    logic [TAG_W-1:0] r_tag;
    btb_entry_t       r_ent;
    logic             r_hit;

    assign r_idx = bus.res_pc[IDX+1:2];
    assign r_tag = bus.res_pc[WIDTH-1:IDX+2];
    assign r_ent = btb_q[r_idx];
    assign r_hit = r_ent.valid && (r_ent.tag == r_tag);

    always_comb begin
        ent_we = 1'b0;
        ent_d  = r_ent;
        if (bus.res_valid) begin
            if (r_hit) begin
                ent_we = 1'b1;
                if (taken) begin
                    ent_d.target = br_target;
                    if (r_ent.ctr != 2'b11) ent_d.ctr = r_ent.ctr + 2'(1);
                end else begin
                    if (r_ent.ctr != 2'b00) ent_d.ctr = r_ent.ctr - 2'(1);
                end
            end else if (taken) begin
                ent_we       = 1'b1;
                ent_d.valid  = 1'b1;
                ent_d.tag    = r_tag;
                ent_d.target = br_target;
                ent_d.ctr    = 2'b10;
            end
        end
    end

    // Saturating statistics
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (bus.res_valid && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
        if (bus.redirect && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
    end

    assign bus.branch_cnt  = branch_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (ent_we) btb_q[r_idx] <= ent_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (ENTRIES=16, CNT_WIDTH=4).
module tb_branch_predict_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    branch_predict_unit_if #(.WIDTH(32), .CNT_WIDTH(4)) bus ();

    branch_predict_unit #(.WIDTH(32), .ENTRIES(16), .CNT_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [2:0] ty,
                           input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] off, input logic pt, input logic [31:0] ptgt);
        bus.res_valid       = 1'b1;
        bus.res_pc          = pc;
        bus.res_type        = ty;
        bus.res_rs          = rs;
        bus.res_rt          = rt;
        bus.res_offset      = off;
        bus.res_pred_taken  = pt;
        bus.res_pred_target = ptgt;
        #1;
    endtask

    task automatic idle();
        bus.res_valid = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fetch_pc        = 32'h0040_0010;
        bus.res_valid       = 1'b0;
        bus.res_pc          = '0;
        bus.res_type        = '0;
        bus.res_rs          = '0;
        bus.res_rt          = '0;
        bus.res_offset      = '0;
        bus.res_pred_taken  = 1'b0;
        bus.res_pred_target = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("por_pred_taken", 32'(bus.pred_taken), 32'd0);
        chk("por_pred_target", bus.pred_target, 32'h0040_0014);

        // Train once, then reset mid-run with a resolve in flight
        resolve(32'h0040_0020, 3'b000, 32'd5, 32'd5, 32'd3, 1'b0, 32'd0);
        chk("pre_rst_redirect", 32'(bus.redirect), 32'd1);
        tick();
        idle();
        bus.fetch_pc = 32'h0040_0020;
        #1;
        chk("pre_rst_trained", 32'(bus.pred_taken), 32'd1);
        resolve(32'h0040_0020, 3'b000, 32'd5, 32'd5, 32'd3, 1'b0, 32'd0);
        bus.fetch_pc = 32'h0040_0010;
        rst = 1'b1;
        #1;
        chk("rst_pred_taken", 32'(bus.pred_taken), 32'd0);
        chk("rst_pred_target", bus.pred_target, 32'h0040_0014);
        chk("rst_branch_cnt", 32'(bus.branch_cnt), 32'd0);
        chk("rst_mispred_cnt", 32'(bus.mispred_cnt), 32'd0);
        tick();
        idle();
        rst = 1'b0;
        bus.fetch_pc = 32'h0040_0020;
        #1;
        chk("rst_entry_miss", 32'(bus.pred_taken), 32'd0);
        chk("rst_entry_target", bus.pred_target, 32'h0040_0024);
        tick();
        chk("rst_no_train_cnt", 32'(bus.branch_cnt), 32'd0);

        // BEQ taken, first encounter
        resolve(32'h0040_0020, 3'b000, 32'd5, 32'd5, 32'd3, 1'b0, 32'd0);
        chk("beq_actual", 32'(bus.actual_taken), 32'd1);
        chk("beq_redirect", 32'(bus.redirect), 32'd1);
        chk("beq_redirect_pc", bus.redirect_pc, 32'h0040_0030);
        tick();
        idle();
        chk("beq_pred_taken", 32'(bus.pred_taken), 32'd1);
        chk("beq_pred_target", bus.pred_target, 32'h0040_0030);

        // Three more correctly-predicted taken resolves
        for (int i = 0; i < 3; i++) begin
            resolve(32'h0040_0020, 3'b000, 32'd5, 32'd5, 32'd3, 1'b1, 32'h0040_0030);
            chk("sat_no_redirect", 32'(bus.redirect), 32'd0);
            tick();
        end
        // Not taken once: ctr 11 -> 10, prediction stays taken
        resolve(32'h0040_0020, 3'b000, 32'd5, 32'd6, 32'd3, 1'b1, 32'h0040_0030);
        chk("nt1_actual", 32'(bus.actual_taken), 32'd0);
        chk("nt1_redirect", 32'(bus.redirect), 32'd1);
        chk("nt1_redirect_pc", bus.redirect_pc, 32'h0040_0024);
        tick();
        idle();
        chk("nt1_still_taken", 32'(bus.pred_taken), 32'd1);
        // Not taken again: ctr 10 -> 01, prediction flips
        resolve(32'h0040_0020, 3'b000, 32'd5, 32'd6, 32'd3, 1'b1, 32'h0040_0030);
        tick();
        idle();
        chk("nt2_pred_taken", 32'(bus.pred_taken), 32'd0);
        chk("nt2_pred_target", bus.pred_target, 32'h0040_0024);
        chk("cnt_branch_6", 32'(bus.branch_cnt), 32'd6);
        chk("cnt_mispred_3", 32'(bus.mispred_cnt), 32'd3);

        // BLTZ with negative rs and negative offset
        resolve(32'h0040_0040, 3'b100, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, 1'b0, 32'd0);
        chk("bltz_actual", 32'(bus.actual_taken), 32'd1);
        chk("bltz_redirect_pc", bus.redirect_pc, 32'h0040_003C);
        chk("bltz_redirect", 32'(bus.redirect), 32'd1);
        tick();
        // BGTZ with rs=0: not taken, predicted not taken
        resolve(32'h0040_0080, 3'b011, 32'd0, 32'd0, 32'd8, 1'b0, 32'd0);
        chk("bgtz_actual", 32'(bus.actual_taken), 32'd0);
        chk("bgtz_redirect", 32'(bus.redirect), 32'd0);
        chk("bgtz_redirect_pc", bus.redirect_pc, 32'h0040_0084);
        tick();

        // Combinational-only condition checks (dropped before the edge)
        resolve(32'h0040_0080, 3'b010, 32'd0, 32'd0, 32'd8, 1'b0, 32'd0);
        chk("blez_zero", 32'(bus.actual_taken), 32'd1);
        resolve(32'h0040_0080, 3'b101, 32'd0, 32'd0, 32'd8, 1'b0, 32'd0);
        chk("bgez_zero", 32'(bus.actual_taken), 32'd1);
        resolve(32'h0040_0080, 3'b101, 32'h8000_0000, 32'd0, 32'd8, 1'b0, 32'd0);
        chk("bgez_neg", 32'(bus.actual_taken), 32'd0);
        resolve(32'h0040_0080, 3'b001, 32'd7, 32'd7, 32'd8, 1'b0, 32'd0);
        chk("bne_equal", 32'(bus.actual_taken), 32'd0);
        resolve(32'h0040_0080, 3'b110, 32'd0, 32'd0, 32'd8, 1'b1, 32'h0040_00A4);
        chk("t110_actual", 32'(bus.actual_taken), 32'd0);
        chk("t110_redirect", 32'(bus.redirect), 32'd1);
        chk("t110_redirect_pc", bus.redirect_pc, 32'h0040_0084);
        resolve(32'h0040_0080, 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd8, 1'b0, 32'd0);
        chk("t111_actual", 32'(bus.actual_taken), 32'd0);
        // Correct direction but wrong target still redirects
        resolve(32'h0040_0080, 3'b000, 32'd1, 32'd1, 32'd8, 1'b1, 32'h0040_0090);
        chk("wrong_target_redirect", 32'(bus.redirect), 32'd1);
        chk("wrong_target_pc", bus.redirect_pc, 32'h0040_00A4);
        idle();
        chk("idle_no_redirect", 32'(bus.redirect), 32'd0);
        tick();

        // Aliasing: 0x00400060 shares index 8 with 0x00400020
        resolve(32'h0040_0060, 3'b000, 32'd2, 32'd2, 32'd3, 1'b0, 32'd0);
        tick();
        idle();
        bus.fetch_pc = 32'h0040_0020;
        #1;
        chk("alias_old_miss", 32'(bus.pred_taken), 32'd0);
        chk("alias_old_target", bus.pred_target, 32'h0040_0024);
        bus.fetch_pc = 32'h0040_0060;
        #1;
        chk("alias_new_taken", 32'(bus.pred_taken), 32'd1);
        chk("alias_new_target", bus.pred_target, 32'h0040_0070);

        // Same-cycle lookup and update: lookup sees the pre-update entry
        bus.fetch_pc = 32'h0040_0040;
        resolve(32'h0040_0040, 3'b100, 32'd1, 32'd0, 32'hFFFF_FFFE, 1'b1, 32'h0040_003C);
        chk("same_cycle_pre", 32'(bus.pred_taken), 32'd1);
        chk("same_cycle_pre_tgt", bus.pred_target, 32'h0040_003C);
        tick();
        idle();
        chk("same_cycle_post", 32'(bus.pred_taken), 32'd0);
        chk("cnt_branch_10", 32'(bus.branch_cnt), 32'd10);
        chk("cnt_mispred_6", 32'(bus.mispred_cnt), 32'd6);

        // Statistics saturation
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            resolve(32'h0040_0100, 3'b000, 32'd9, 32'd9, 32'd1, 1'b0, 32'd0);
            tick();
            if (i == 14) begin
                chk("sat_branch_15", 32'(bus.branch_cnt), 32'd15);
                chk("sat_mispred_15", 32'(bus.mispred_cnt), 32'd15);
            end
        end
        idle();
        chk("sat_branch_hold", 32'(bus.branch_cnt), 32'd15);
        chk("sat_mispred_hold", 32'(bus.mispred_cnt), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
